mips_fwd_hazard_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_fwd_sel_cmp.sv | 42 ++++
 rtl/mips_fwd_hazard_unit.sv | 133 +++++++++++++
 tb/tb_mips_fwd_hazard_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: forwarding select encodings and the stage-slot record.
package mips_pkg;

    localparam logic [1:0] FWD_SEL_RF    = 2'b00;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'b01;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;

    localparam int MIPS_REG_ADDR_W = 5;
    localparam int REG_ZERO        = 0;

    typedef struct packed {
        logic                       valid;
        logic [MIPS_REG_ADDR_W-1:0] rd;
        logic                       we;
        logic                       mr;
    } slot_t;

    // Number of operands in a cycle that take a bypass path instead of the register file.
    function automatic logic [1:0] fwd_count(input logic [1:0] a_sel, input logic [1:0] b_sel);
        fwd_count = {1'b0, (a_sel != FWD_SEL_RF)} + {1'b0, (b_sel != FWD_SEL_RF)};
    endfunction

endpackage

// File: rtl/mips_fwd_sel_cmp.sv
// Single-operand forwarding select: picks the youngest in-flight producer of the EX source register.
module mips_fwd_sel_cmp
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W
) (
    input  logic                  ex_valid,
    input  logic                  ex_use,
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic                  mem_mr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

    logic need;
    logic mem_hit;
    logic wb_hit;

    assign need = ex_valid & ex_use;

    // A load in MEM has no data on the EX/MEM bypass yet; the load-use stall keeps
    // this case from arising, and the gate stops an address ever being forwarded.
    assign mem_hit = mem_valid & mem_we & ~mem_mr & (mem_rd != RZ) & (mem_rd == ex_src);
    assign wb_hit  = wb_valid & wb_we & (wb_rd != RZ) & (wb_rd == ex_src);

    always_comb begin
        sel = FWD_SEL_RF;
        if (need && mem_hit) begin
            sel = FWD_SEL_EXMEM;
        end else if (need && wb_hit) begin
            sel = FWD_SEL_MEMWB;
        end
    end

endmodule

// File: rtl/mips_fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage MIPS pipeline.
// Optional FWD_HAZARD_PERF_CNT_EN adds stall_cnt / fwd_cnt performance counters.
module mips_fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = MIPS_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  idex_bubble
`ifdef FWD_HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

    logic                  ex_vld_p0;
    logic [REG_ADDR_W-1:0] ex_rs_p0;
    logic [REG_ADDR_W-1:0] ex_rt_p0;
    logic                  ex_use_rs_p0;
    logic                  ex_use_rt_p0;
    logic [REG_ADDR_W-1:0] ex_rd_p0;
    logic                  ex_we_p0;
    logic                  ex_mr_p0;

    slot_t                 mem_p1;

    logic                  wb_vld_p2;
    logic [REG_ADDR_W-1:0] wb_rd_p2;
    logic                  wb_we_p2;

    logic                  ex_take;
    logic                  ex_load_live;

    assign ex_take = ~idex_bubble;

    // ID -> EX -> MEM -> WB tracking; only the valid/we/mr control bits are reset
    always_ff @(posedge clk) begin
        ex_rs_p0     <= id_rs;
        ex_rt_p0     <= id_rt;
        ex_use_rs_p0 <= id_use_rs;
        ex_use_rt_p0 <= id_use_rt;
        ex_rd_p0     <= id_rd;
        mem_p1.rd    <= ex_rd_p0;
        wb_rd_p2     <= mem_p1.rd;
        if (rst) begin
            ex_vld_p0    <= 1'b0;
            ex_we_p0     <= 1'b0;
            ex_mr_p0     <= 1'b0;
            mem_p1.valid <= 1'b0;
            mem_p1.we    <= 1'b0;
            mem_p1.mr    <= 1'b0;
            wb_vld_p2    <= 1'b0;
            wb_we_p2     <= 1'b0;
        end else begin
            ex_vld_p0    <= id_valid & ex_take;
            ex_we_p0     <= id_reg_write & ex_take;
            ex_mr_p0     <= id_mem_read & ex_take;
            mem_p1.valid <= ex_vld_p0;
            mem_p1.we    <= ex_we_p0;
            mem_p1.mr    <= ex_mr_p0;
            wb_vld_p2    <= mem_p1.valid;
            wb_we_p2     <= mem_p1.we;
        end
    end

    mips_fwd_sel_cmp #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_sel_a (
        .ex_valid (ex_vld_p0),
        .ex_use   (ex_use_rs_p0),
        .ex_src   (ex_rs_p0),
        .mem_valid(mem_p1.valid),
        .mem_we   (mem_p1.we),
        .mem_mr   (mem_p1.mr),
        .mem_rd   (mem_p1.rd),
        .wb_valid (wb_vld_p2),
        .wb_we    (wb_we_p2),
        .wb_rd    (wb_rd_p2),
        .sel      (fwd_a_sel)
    );

    mips_fwd_sel_cmp #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_sel_b (
        .ex_valid (ex_vld_p0),
        .ex_use   (ex_use_rt_p0),
        .ex_src   (ex_rt_p0),
        .mem_valid(mem_p1.valid),
        .mem_we   (mem_p1.we),
        .mem_mr   (mem_p1.mr),
        .mem_rd   (mem_p1.rd),
        .wb_valid (wb_vld_p2),
        .wb_we    (wb_we_p2),
        .wb_rd    (wb_rd_p2),
        .sel      (fwd_b_sel)
    );

    // A load in EX whose result the ID instruction needs: hold ID for one cycle.
    assign ex_load_live = ex_vld_p0 & ex_we_p0 & ex_mr_p0 & (ex_rd_p0 != RZ);
    assign stall        = id_valid & ex_load_live &
                          ((id_use_rs & (id_rs == ex_rd_p0)) | (id_use_rt & (id_rt == ex_rd_p0)));
    assign idex_bubble  = stall | flush;

`ifdef FWD_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall);
            fwd_cnt   <= fwd_cnt + CNT_W'(fwd_count(fwd_a_sel, fwd_b_sel));
        end
    end
`endif

endmodule

// File: tb/tb_mips_fwd_hazard_unit.sv
// Directed vector bench for mips_fwd_hazard_unit (optional FWD_HAZARD_PERF_CNT_EN counters).
module tb_mips_fwd_hazard_unit;

    localparam int W     = 5;
    localparam int CNT_W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid;
    logic [W-1:0] id_rs;
    logic [W-1:0] id_rt;
    logic         id_use_rs;
    logic         id_use_rt;
    logic [W-1:0] id_rd;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         flush;
    logic [1:0]   fwd_a_sel;
    logic [1:0]   fwd_b_sel;
    logic         stall;
    logic         idex_bubble;
`ifdef FWD_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;
`endif

    always #5 clk = ~clk;

    mips_fwd_hazard_unit #(
        .REG_ADDR_W(W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .idex_bubble (idex_bubble)
`ifdef FWD_HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    typedef struct {
        logic         rst;
        logic         v;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic         urs;
        logic         urt;
        logic [W-1:0] rd;
        logic         we;
        logic         mr;
        logic         fl;
        logic         chk;
        logic [1:0]   a;
        logic [1:0]   b;
        logic         st;
        logic         bub;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    function automatic vec_t mk(input logic r, input logic v, input int rs, input int rt,
                                input logic urs, input logic urt, input int rd, input logic we,
                                input logic mr, input logic fl, input logic chk,
                                input logic [1:0] a, input logic [1:0] b, input logic st,
                                input logic bub);
        vec_t t;
        t.rst = r;  t.v = v;  t.rs = W'(rs);  t.rt = W'(rt);
        t.urs = urs; t.urt = urt; t.rd = W'(rd); t.we = we; t.mr = mr; t.fl = fl;
        t.chk = chk; t.a = a; t.b = b; t.st = st; t.bub = bub;
        return t;
    endfunction

    function automatic vec_t nop(input logic r, input logic [1:0] a, input logic [1:0] b);
        return mk(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a, b, 0, 0);
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.v; id_rs = t.rs; id_rt = t.rt;
        id_use_rs = t.urs; id_use_rt = t.urt; id_rd = t.rd;
        id_reg_write = t.we; id_mem_read = t.mr; flush = t.fl;
    endtask

    // A load sitting in MEM must never match a source of the instruction in EX.
    always @(negedge clk) begin
        #2;
        if (mon_en && dut.mem_p1.valid && dut.mem_p1.mr && dut.mem_p1.we &&
            (dut.mem_p1.rd != '0) && dut.ex_vld_p0 &&
            ((dut.ex_use_rs_p0 && dut.ex_rs_p0 == dut.mem_p1.rd) ||
             (dut.ex_use_rt_p0 && dut.ex_rt_p0 == dut.mem_p1.rd))) begin
            failures++;
            $display("FAIL load_mem_ex_match got=1 expected=0");
        end
    end

    initial begin
        int stall_seen;
        bit entered;
`ifdef FWD_HAZARD_PERF_CNT_EN
        logic [CNT_W-1:0] exp_stall_cnt = '0;
        logic [CNT_W-1:0] exp_fwd_cnt   = '0;
`endif
        // reset state
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(1, 2'b00, 2'b00));
        // EX->EX on rs
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3, 4, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b10, 2'b00));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        // MEM->EX on rt with one unrelated instruction between
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 8, 9, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 11, 5, 1, 1, 12, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b01));
        // two producers of $7: younger wins
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 7, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3, 4, 1, 1, 7, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 7, 7, 1, 1, 13, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b10, 2'b10));
        // load-use: one stall cycle, consumer held, then MEM/WB forward
        tbl.push_back(mk(0, 1, 1, 4, 1, 0, 4, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 4, 2, 1, 1, 14, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2, 1, 1, 14, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b01, 2'b00));
        // $0 never forwards, load to $0 never stalls
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 15, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 16, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        // flush during a load-use stall
        tbl.push_back(mk(0, 1, 1, 9, 1, 0, 9, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 9, 9, 1, 1, 17, 1, 0, 1, 1, 2'b00, 2'b00, 1, 1));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 1, 17, 9, 1, 1, 18, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        // flush alone squashes a producer
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 19, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 19, 19, 1, 1, 20, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        // reset in the middle of a load-use stall
        tbl.push_back(mk(0, 1, 1, 4, 1, 0, 4, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 4, 2, 1, 1, 21, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2, 1, 1, 21, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        // reset discards a pending forward
        tbl.push_back(mk(0, 1, 1, 2, 1, 1, 22, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 22, 22, 1, 1, 23, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(nop(0, 2'b00, 2'b00));
        tbl.push_back(nop(0, 2'b00, 2'b00));

        drive(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            if (i == 1) mon_en = 1'b1;
            if (tbl[i].chk) begin
                cmp("fwd_a_sel", i, 32'(fwd_a_sel), 32'(tbl[i].a));
                cmp("fwd_b_sel", i, 32'(fwd_b_sel), 32'(tbl[i].b));
                cmp("stall", i, 32'(stall), 32'(tbl[i].st));
                cmp("idex_bubble", i, 32'(idex_bubble), 32'(tbl[i].bub));
`ifdef FWD_HAZARD_PERF_CNT_EN
                cmp("stall_cnt", i, stall_cnt, exp_stall_cnt);
                cmp("fwd_cnt", i, fwd_cnt, exp_fwd_cnt);
`endif
            end
`ifdef FWD_HAZARD_PERF_CNT_EN
            if (tbl[i].rst) begin
                exp_stall_cnt = '0;
                exp_fwd_cnt   = '0;
            end else begin
                exp_stall_cnt = exp_stall_cnt + CNT_W'(tbl[i].st);
                exp_fwd_cnt   = exp_fwd_cnt + CNT_W'(tbl[i].a != 2'b00) + CNT_W'(tbl[i].b != 2'b00);
            end
`endif
        end

        // Reactive load-use: hold the consumer in ID while stall is high.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
        drive(mk(0, 1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
        drive(mk(0, 1, 8, 8, 1, 1, 24, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        stall_seen = 0;
        entered    = 1'b0;
        for (int c = 0; c < 5 && !entered; c++) begin
            #1;
            if (stall) stall_seen++;
            else entered = 1'b1;
            @(negedge clk);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        #1;
        cmp("reactive_entered", 0, 32'(entered), 32'd1);
        cmp("reactive_stall_cycles", 0, 32'(stall_seen), 32'd1);
        cmp("reactive_fwd_a_sel", 0, 32'(fwd_a_sel), 32'(2'b01));
        cmp("reactive_fwd_b_sel", 0, 32'(fwd_b_sel), 32'(2'b01));

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
